// File: rtl/maxpool_pkg.sv
// Shared FP32 field layout, constants and sizing helpers for the max-pooling blocks.
package maxpool_pkg;

    localparam int SIGN_BIT = 31;
    localparam int EXP_MSB  = 30;
    localparam int EXP_LSB  = 23;
    localparam int MAG_MSB  = 30;

    typedef struct packed {
        logic                     sign;
        logic [EXP_MSB-EXP_LSB:0] exponent;
        logic [EXP_LSB-1:0]       fraction;
    } fp32_t;

    localparam fp32_t FP32_ZERO = '0;

    // Counter/index width that never collapses to zero bits for tiny sizes.
    function automatic int cnt_width(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/fp32_max2.sv
// Combinational FP32 max of two operands; on an equal compare the earlier operand a is kept.
module fp32_max2
    import maxpool_pkg::*;
(
    input  fp32_t a,
    input  fp32_t b,
    output fp32_t y
);

    logic [MAG_MSB:0] a_mag;
    logic [MAG_MSB:0] b_mag;
    logic             a_neg;
    logic             b_neg;

    assign a_mag = a[MAG_MSB:0];
    assign b_mag = b[MAG_MSB:0];
    assign a_neg = a[SIGN_BIT];
    assign b_neg = b[SIGN_BIT];

    // +0 and -0 compare equal, so both-zero is checked before the sign rule.
    always_comb begin
        y = a;
        if ((a_mag == '0) && (b_mag == '0)) begin
            y = a;
        end else if (a_neg != b_neg) begin
            y = a_neg ? b : a;
        end else if (!a_neg) begin
            y = (b_mag > a_mag) ? b : a;
        end else begin
            y = (b_mag < a_mag) ? b : a;
        end
    end

endmodule

// File: rtl/maxpool_2x2_stride_2.sv
// Streaming 2x2 / stride-2 FP32 max-pooling stage; one half-width row of horizontal maxima is buffered.
module maxpool_2x2_stride_2
    import maxpool_pkg::*;
#(
    parameter int DATA_WIDHT = 32,
    parameter int IMG_WIDHT  = 44,
    parameter int IMG_HEIGHT = 44
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DATA_WIDHT-1:0] Data_In,
    input  logic                  Valid_In,
    output logic [DATA_WIDHT-1:0] Data_Out,
    output logic                  Valid_Out,
    output logic                  Frame_Done
);

    localparam int OUT_W = IMG_WIDHT / 2;
    localparam int OUT_H = IMG_HEIGHT / 2;
    localparam int COL_W = cnt_width(IMG_WIDHT);
    localparam int ROW_W = cnt_width(IMG_HEIGHT);
    localparam int IDX_W = cnt_width(OUT_W);

    localparam logic [COL_W-1:0] COL_LAST     = COL_W'(IMG_WIDHT - 1);
    localparam logic [ROW_W-1:0] ROW_LAST     = ROW_W'(IMG_HEIGHT - 1);
    localparam logic [COL_W-1:0] COL_LAST_WIN = COL_W'(2 * OUT_W - 1);
    localparam logic [ROW_W-1:0] ROW_LAST_WIN = ROW_W'(2 * OUT_H - 1);

    logic [COL_W-1:0]      col;
    logic [ROW_W-1:0]      row;
    logic [DATA_WIDHT-1:0] h_reg;
    logic [DATA_WIDHT-1:0] row_buf [OUT_W];
    logic [IDX_W-1:0]      buf_idx;
    logic [DATA_WIDHT-1:0] buf_rd;
    logic [DATA_WIDHT-1:0] hmax;
    logic [DATA_WIDHT-1:0] pooled;
    logic                  last_window;

    assign buf_idx     = IDX_W'(col >> 1);
    assign buf_rd      = row_buf[buf_idx];
    assign last_window = (row == ROW_LAST_WIN) && (col == COL_LAST_WIN);

    fp32_max2 u_hmax (
        .a (h_reg),
        .b (Data_In),
        .y (hmax)
    );

    fp32_max2 u_vmax (
        .a (buf_rd),
        .b (hmax),
        .y (pooled)
    );

    // Odd trailing columns/rows fall on even indices, so they never complete a window.
    always_ff @(posedge clk) begin
        if (rst) begin
            col        <= '0;
            row        <= '0;
            h_reg      <= FP32_ZERO;
            Data_Out   <= FP32_ZERO;
            Valid_Out  <= 1'b0;
            Frame_Done <= 1'b0;
        end else begin
            Valid_Out  <= 1'b0;
            Frame_Done <= 1'b0;
            if (Valid_In) begin
                if (col == COL_LAST) begin
                    col <= '0;
                    row <= (row == ROW_LAST) ? '0 : row + ROW_W'(1);
                end else begin
                    col <= col + COL_W'(1);
                end

                if (!col[0]) begin
                    h_reg <= Data_In;
                end else if (row[0]) begin
                    Data_Out   <= pooled;
                    Valid_Out  <= 1'b1;
                    Frame_Done <= last_window;
                end
            end
        end
    end

    // The row buffer has no reset: every entry is written on an even row before it is read.
    always_ff @(posedge clk) begin
        if (!rst && Valid_In && col[0] && !row[0]) begin
            row_buf[buf_idx] <= hmax;
        end
    end

endmodule

// File: tb/tb_maxpool_2x2_stride_2.sv
// Directed bench for maxpool_2x2_stride_2 using 4x4, 2x2 and 5x5 instances on one clock.
module tb_maxpool_2x2_stride_2;

    logic        clk;
    logic        rst;

    logic [31:0] d4, q4, d2, q2, d5, q5;
    logic        v4, vo4, fd4, v2, vo2, fd2, v5, vo5, fd5;

    int compared   = 0;
    int mismatched = 0;
    int fd_count5  = 0;

    logic [31:0] fp [1:25];
    logic [31:0] cap4 [$];
    logic        capfd4 [$];
    logic [31:0] cap5 [$];
    logic        capfd5 [$];
    int          exp4 [4];
    int          exp5 [4];
    int          k;

    maxpool_2x2_stride_2 #(.DATA_WIDHT(32), .IMG_WIDHT(4), .IMG_HEIGHT(4)) dut4 (
        .clk(clk), .rst(rst), .Data_In(d4), .Valid_In(v4),
        .Data_Out(q4), .Valid_Out(vo4), .Frame_Done(fd4)
    );

    maxpool_2x2_stride_2 #(.DATA_WIDHT(32), .IMG_WIDHT(2), .IMG_HEIGHT(2)) dut2 (
        .clk(clk), .rst(rst), .Data_In(d2), .Valid_In(v2),
        .Data_Out(q2), .Valid_Out(vo2), .Frame_Done(fd2)
    );

    maxpool_2x2_stride_2 #(.DATA_WIDHT(32), .IMG_WIDHT(5), .IMG_HEIGHT(5)) dut5 (
        .clk(clk), .rst(rst), .Data_In(d5), .Valid_In(v5),
        .Data_Out(q5), .Valid_Out(vo5), .Frame_Done(fd5)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (vo4) begin
            cap4.push_back(q4);
            capfd4.push_back(fd4);
        end
        if (vo5) begin
            cap5.push_back(q5);
            capfd5.push_back(fd5);
        end
        if (fd5) fd_count5++;
    end

    // Drives one cycle of input to the selected instance, then samples 1 time unit after the edge.
    task automatic applyStimulus(input int sel, input logic [31:0] d, input logic v);
        d4 = 32'h0; v4 = 1'b0;
        d2 = 32'h0; v2 = 1'b0;
        d5 = 32'h0; v5 = 1'b0;
        case (sel)
            4: begin d4 = d; v4 = v; end
            2: begin d2 = d; v2 = v; end
            5: begin d5 = d; v5 = v; end
            default: ;
        endcase
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        compared++;
        assert (observed === expected) else begin
            mismatched++;
            $error("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
        end
    endtask

    initial begin
        fp = '{32'h3F800000, 32'h40000000, 32'h40400000, 32'h40800000, 32'h40A00000,
               32'h40C00000, 32'h40E00000, 32'h41000000, 32'h41100000, 32'h41200000,
               32'h41300000, 32'h41400000, 32'h41500000, 32'h41600000, 32'h41700000,
               32'h41800000, 32'h41880000, 32'h41900000, 32'h41980000, 32'h41A00000,
               32'h41A80000, 32'h41B00000, 32'h41B80000, 32'h41C00000, 32'h41C80000};
        exp4 = '{6, 8, 14, 16};
        exp5 = '{7, 9, 17, 19};

        rst = 1'b1;
        d4 = 32'h0; v4 = 1'b0;
        d2 = 32'h0; v2 = 1'b0;
        d5 = 32'h0; v5 = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checkOutput("reset_data", q4, 32'h0);
        checkOutput("reset_valid", {31'b0, vo4}, 32'h0);
        checkOutput("reset_done", {31'b0, fd4}, 32'h0);
        rst = 1'b0;

        $display("[TB] basic 4x4, cycle-exact");
        k = 0;
        for (int i = 0; i < 16; i++) begin
            applyStimulus(4, fp[i+1], 1'b1);
            if (((i / 4) % 2 == 1) && ((i % 4) % 2 == 1)) begin
                checkOutput($sformatf("basic_valid_%0d", i), {31'b0, vo4}, 32'h1);
                checkOutput($sformatf("basic_data_%0d", i), q4, fp[exp4[k]]);
                checkOutput($sformatf("basic_done_%0d", i), {31'b0, fd4}, {31'b0, (i == 15)});
                k++;
            end else begin
                checkOutput($sformatf("basic_novalid_%0d", i), {31'b0, vo4}, 32'h0);
            end
        end
        applyStimulus(4, 32'h0, 1'b0);
        applyStimulus(4, 32'h0, 1'b0);
        checkOutput("hold_data", q4, fp[16]);
        checkOutput("hold_valid", {31'b0, vo4}, 32'h0);

        $display("[TB] 4x4 with input bubbles");
        cap4.delete();
        capfd4.delete();
        for (int i = 0; i < 16; i++) begin
            applyStimulus(4, fp[i+1], 1'b1);
            repeat ($urandom_range(0, 3)) applyStimulus(4, 32'h0, 1'b0);
        end
        repeat (3) applyStimulus(4, 32'h0, 1'b0);
        checkOutput("bubble_count", cap4.size(), 32'd4);
        for (int j = 0; j < 4; j++) begin
            checkOutput($sformatf("bubble_data_%0d", j), cap4[j], fp[exp4[j]]);
            checkOutput($sformatf("bubble_done_%0d", j), {31'b0, capfd4[j]}, {31'b0, (j == 3)});
        end

        $display("[TB] reset mid-frame");
        cap4.delete();
        capfd4.delete();
        for (int i = 0; i < 5; i++) applyStimulus(4, fp[i+1], 1'b1);
        applyStimulus(4, 32'h0, 1'b0);
        rst = 1'b1;
        applyStimulus(4, fp[25], 1'b1);
        rst = 1'b0;
        checkOutput("midrst_data", q4, 32'h0);
        checkOutput("midrst_valid", {31'b0, vo4}, 32'h0);
        for (int i = 0; i < 16; i++) applyStimulus(4, fp[i+1], 1'b1);
        repeat (3) applyStimulus(4, 32'h0, 1'b0);
        checkOutput("midrst_count", cap4.size(), 32'd4);
        for (int j = 0; j < 4; j++) begin
            checkOutput($sformatf("midrst_out_%0d", j), cap4[j], fp[exp4[j]]);
        end

        $display("[TB] 2x2 sign cases");
        applyStimulus(2, 32'hC0400000, 1'b1);
        applyStimulus(2, 32'hBF800000, 1'b1);
        applyStimulus(2, 32'hC0400000, 1'b1);
        checkOutput("neg_novalid", {31'b0, vo2}, 32'h0);
        applyStimulus(2, 32'hC0400000, 1'b1);
        checkOutput("neg_valid", {31'b0, vo2}, 32'h1);
        checkOutput("neg_data", q2, 32'hBF800000);
        checkOutput("neg_done", {31'b0, fd2}, 32'h1);

        applyStimulus(2, 32'h80000000, 1'b1);
        applyStimulus(2, 32'h00000000, 1'b1);
        applyStimulus(2, 32'h00000000, 1'b1);
        applyStimulus(2, 32'h00000000, 1'b1);
        checkOutput("zero_valid", {31'b0, vo2}, 32'h1);
        checkOutput("zero_data", q2, 32'h80000000);

        applyStimulus(2, 32'hBF800000, 1'b1);
        applyStimulus(2, 32'h3F800000, 1'b1);
        applyStimulus(2, 32'h40000000, 1'b1);
        applyStimulus(2, 32'hC0000000, 1'b1);
        checkOutput("mixed_data", q2, 32'h40000000);
        applyStimulus(2, 32'h0, 1'b0);
        checkOutput("mixed_pulse_end", {31'b0, vo2}, 32'h0);

        $display("[TB] 5x5 odd dimensions, two frames back-to-back");
        for (int f = 0; f < 2; f++) begin
            for (int i = 0; i < 25; i++) applyStimulus(5, fp[i+1], 1'b1);
        end
        repeat (3) applyStimulus(5, 32'h0, 1'b0);
        checkOutput("odd_count", cap5.size(), 32'd8);
        checkOutput("odd_done_pulses", fd_count5, 32'd2);
        for (int j = 0; j < 8; j++) begin
            checkOutput($sformatf("odd_data_%0d", j), cap5[j], fp[exp5[j % 4]]);
            checkOutput($sformatf("odd_done_%0d", j), {31'b0, capfd5[j]}, {31'b0, (j % 4 == 3)});
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/maxpool_2x2_stride_2.md
Name: maxpool_2x2_stride_2

Overview:
- Streaming 2x2 / stride-2 max-pooling stage directly downstream of the 3x3/stride-1/pad-1 max-pooling block.
- Consumes its raster-order FP32 pixel stream (one pixel per Valid_In cycle) and halves width and height.
- Buffers one half-width row of horizontal partial maxima.
- Emits one pooled FP32 pixel per 2x2 window in raster order.

Parameters:
- DATA_WIDHT, 32, pixel width; the block is FP32-only and requires 32.
- IMG_WIDHT, 44, input image width in pixels.
- IMG_HEIGHT, 44, input image height in pixels.

Ports:
- clk  input  1  clock, rising edge.
- rst  input  1  reset; synchronous, active-high.
- Data_In  input  32  IEEE-754 single-precision pixel, raster order.
- Valid_In  input  1  Data_In is valid this cycle; no backpressure.
- Data_Out  output  32  pooled pixel, IEEE-754 single precision.
- Valid_Out  output  1  Data_Out is valid; one-cycle pulse per pooled pixel.
- Frame_Done  output  1  one-cycle pulse with the last pooled pixel of a frame.

Behaviour:
- Clock and reset: one clock (clk). Reset is synchronous, active-high (rst).
- Reset values: Data_Out=0, Valid_Out=0, Frame_Done=0, col=0, row=0, horizontal holding register=0. The row buffer is not cleared; it is always written before it is read.
- Counting: col (0..IMG_WIDHT-1) and row (0..IMG_HEIGHT-1) advance only on Valid_In.
  - col wraps to 0 at IMG_WIDHT-1, then row increments.
  - row wraps to 0 at IMG_HEIGHT-1 with col wrap (frame end). The next frame follows back-to-back with no idle cycle required.
- Horizontal pass:
  - Even col: latch pixel into h_reg.
  - Odd col: hmax = max(h_reg, Data_In).
- Vertical pass:
  - Even row, odd col: write hmax to row_buf[col>>1].
  - Odd row, odd col: pooled = max(row_buf[col>>1], hmax). Register pooled into Data_Out and assert Valid_Out on the next cycle (latency 1 clk from the completing input).
- Odd dimensions: the floor rule applies.
  - Odd IMG_WIDHT: last column is consumed but ignored.
  - Odd IMG_HEIGHT: last row is consumed but ignored.
  - Output per frame is (IMG_WIDHT/2)*(IMG_HEIGHT/2) pixels.
- Frame_Done: asserted in the same cycle as Valid_Out for the pooled pixel at output position (IMG_HEIGHT/2-1, IMG_WIDHT/2-1).
- Data_Out holds its last value when Valid_Out=0.
- FP32 max rule (fp32_max2, operands a=earlier/left/top, b=later):
  - Signs differ: the non-negative operand wins.
  - Both positive: larger magnitude bits [30:0] win.
  - Both negative: smaller magnitude bits win.
  - Equal compare, including +0 vs -0: result is a.
  - NaN/Inf are not expected and are compared by the same bit rules; no special handling.
- Reset mid-frame:
  - Counters and h_reg clear and Valid_Out drops in the next cycle.
  - The first Valid_In after rst deasserts is pixel (0,0) of a new frame.
  - Partial windows are discarded.
- rst and Valid_In high together: rst wins and the input is dropped.
- Row buffer depth: IMG_WIDHT/2 entries x 32 bits; the index is col>>1, width $clog2(IMG_WIDHT/2) (minimum 1).

Decomposition:
- Shared package (maxpool_pkg):
  - FP32 field constants: SIGN_BIT=31, EXP_MSB=30, EXP_LSB=23, MAG_MSB=30.
  - Counter width function built on $clog2.
  - FP32_ZERO constant.
- Sub-module fp32_max2: combinational two-operand max with the tie rule above. It is reusable by the 3x3 max core.
- Top level: counters, h_reg, row_buf, output register.

Test Plan:
- Basic 4x4 pooling (IMG_WIDHT=IMG_HEIGHT=4).
  - Stimulus: pixels 1.0..16.0 in raster order, continuous valid.
  - Response: Data_Out 0x40C00000 (6.0), 0x41000000 (8.0), 0x41600000 (14.0), 0x41800000 (16.0).
  - Each appears 1 clk after inputs (1,1), (1,3), (3,1), (3,3); Frame_Done only with 16.0.
- Negative values (2x2 frame).
  - Stimulus: window {0xC0400000, 0xBF800000, 0xC0400000, 0xC0400000}.
  - Response: Data_Out=0xBF800000 (-1.0).
- Signed zero tie (2x2 frame).
  - Stimulus: window {0x80000000, 0x00000000, 0x00000000, 0x00000000}.
  - Response: Data_Out=0x80000000 (first operand kept on tie).
- Valid_In bubbles (4x4 stimulus of the basic test).
  - Stimulus: 0-3 idle cycles inserted randomly between pixels.
  - Response: identical output values and order; Valid_Out count 4.
- Reset mid-frame.
  - Stimulus: 4x4 frame; assert rst one cycle after pixel 5; then send a full 4x4 frame of 1.0..16.0.
  - Response: no Valid_Out from the partial frame; outputs 6.0, 8.0, 14.0, 16.0.
- Odd dimensions (IMG_WIDHT=IMG_HEIGHT=5).
  - Stimulus: pixels 1.0..25.0, immediately followed by a second frame.
  - Response: 7.0, 9.0, 17.0, 19.0 per frame; two Frame_Done pulses; no cross-frame mixing.
